// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan capture block: segment codes
// ({g,f,e,d,c,b,a}, active low) and the capture FSM state encoding.
package sseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/sseg_decode.sv
// Combinational lookup from an active-low segment pattern to a hex nibble,
// flagging the all-off pattern and anything that is not a legal glyph.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       is_blank,
    output logic       is_bad
);

    always_comb begin
        nibble   = 4'h0;
        is_blank = 1'b0;
        is_bad   = 1'b0;
        case (seg_n)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_capture.sv
// Snoops a multiplexed seven-segment display: synchronizes the scan lines,
// waits for them to settle, then latches the decoded digit per position.
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic [6:0]              seg_n,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   bad,
    output logic                    frame,
    output logic                    scan_err
);

    localparam logic [7:0]            STABLE_LIM = 8'(STABLE_CYC);
    localparam logic [NUM_DIGITS-1:0] ONE        = NUM_DIGITS'(1);

    logic [NUM_DIGITS-1:0]   an_meta_reg, an_sync_reg, an_last_reg;
    logic [6:0]              seg_meta_reg, seg_sync_reg, seg_last_reg;
    state_t                  state_reg, state_next;
    logic [7:0]              cnt_reg, cnt_next;
    logic [NUM_DIGITS-1:0]   seen_reg, seen_next;
    logic [4*NUM_DIGITS-1:0] digits_reg, digits_next;
    logic [NUM_DIGITS-1:0]   blank_reg, blank_next;
    logic [NUM_DIGITS-1:0]   bad_reg, bad_next;
    logic                    frame_reg, scan_err_reg;

    logic                    change, evaluate, one_hot, capture, seen_full;
    logic [NUM_DIGITS-1:0]   sel, cap_mask;
    logic [3:0]              nibble;
    logic                    is_blank, is_bad;

    sseg_decode u_decode (
        .seg_n    (seg_sync_reg),
        .nibble   (nibble),
        .is_blank (is_blank),
        .is_bad   (is_bad)
    );

    // The *_last copies trail the synchronized inputs by one cycle so any
    // difference marks a fresh edge on the scan lines.
    assign change  = (an_sync_reg != an_last_reg) || (seg_sync_reg != seg_last_reg);
    assign sel     = ~an_sync_reg;
    assign one_hot = (sel != '0) && ((sel & (sel - ONE)) == '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        evaluate   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (change) begin
                    state_next = SETTLE;
                    cnt_next   = 8'd1;
                end
            end
            SETTLE: begin
                if (change) begin
                    cnt_next = 8'd1;
                end else if (cnt_reg >= STABLE_LIM) begin
                    evaluate   = 1'b1;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            HOLD: begin
                if (change) begin
                    state_next = SETTLE;
                    cnt_next   = 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    assign capture   = evaluate && one_hot;
    assign cap_mask  = capture ? sel : '0;
    assign seen_full = &seen_reg;
    // A capture landing on the clearing cycle still registers as seen.
    assign seen_next = (seen_full ? '0 : seen_reg) | cap_mask;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
        assign digits_next[4*gi +: 4] = cap_mask[gi] ? nibble   : digits_reg[4*gi +: 4];
        assign blank_next[gi]         = cap_mask[gi] ? is_blank : blank_reg[gi];
        assign bad_next[gi]           = cap_mask[gi] ? is_bad   : bad_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta_reg  <= '1;
            an_sync_reg  <= '1;
            an_last_reg  <= '1;
            seg_meta_reg <= '1;
            seg_sync_reg <= '1;
            seg_last_reg <= '1;
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            seen_reg     <= '0;
            digits_reg   <= '0;
            blank_reg    <= '1;
            bad_reg      <= '0;
            frame_reg    <= 1'b0;
            scan_err_reg <= 1'b0;
        end else begin
            an_meta_reg  <= an_n;
            an_sync_reg  <= an_meta_reg;
            an_last_reg  <= an_sync_reg;
            seg_meta_reg <= seg_n;
            seg_sync_reg <= seg_meta_reg;
            seg_last_reg <= seg_sync_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            seen_reg     <= seen_next;
            digits_reg   <= digits_next;
            blank_reg    <= blank_next;
            bad_reg      <= bad_next;
            frame_reg    <= seen_full;
            scan_err_reg <= evaluate && !one_hot;
        end
    end

    assign digits   = digits_reg;
    assign blank    = blank_reg;
    assign bad      = bad_reg;
    assign frame    = frame_reg;
    assign scan_err = scan_err_reg;

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture: a reference model pushes expected output
// snapshots to a queue as stimulus is driven; they are popped after the dwell.
module tb_sseg_capture;

    logic        clk;
    logic        rst_n;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  bad;
    logic        frame;
    logic        scan_err;

    sseg_capture #(.NUM_DIGITS(8), .STABLE_CYC(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .digits   (digits),
        .blank    (blank),
        .bad      (bad),
        .frame    (frame),
        .scan_err (scan_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [31:0] d;
        logic [7:0]  b;
        logic [7:0]  x;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          frame_cnt  = 0;
    int          err_cnt    = 0;
    logic [31:0] exp_d;
    logic [7:0]  exp_b;
    logic [7:0]  exp_x;
    logic [6:0]  segtab [16];

    always @(negedge clk) begin
        if (frame === 1'b1) frame_cnt++;
        if (scan_err === 1'b1) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        exp_d = 32'h0;
        exp_b = 8'hFF;
        exp_x = 8'h00;
    endtask

    task automatic model_cap(input int pos, input logic [3:0] nib, input logic bl, input logic bd);
        exp_d[4*pos +: 4] = nib;
        exp_b[pos]        = bl;
        exp_x[pos]        = bd;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.d   = exp_d;
        e.b   = exp_b;
        e.x   = exp_x;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        compared++;
        assert (sb.size() != 0) else begin
            mismatched++;
            $error("FAIL scoreboard: observed=empty expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_digits"}, digits, e.d);
            chk({e.tag, "_blank"}, {24'h0, blank}, {24'h0, e.b});
            chk({e.tag, "_bad"}, {24'h0, bad}, {24'h0, e.x});
            $display("step %s: digits=%h blank=%h bad=%h", e.tag, digits, blank, bad);
        end
    endtask

    task automatic drive(input logic [7:0] an, input logic [6:0] seg);
        an_n  = an;
        seg_n = seg;
    endtask

    initial begin
        segtab[0]  = 7'b1000000; segtab[1]  = 7'b1111001;
        segtab[2]  = 7'b0100100; segtab[3]  = 7'b0110000;
        segtab[4]  = 7'b0011001; segtab[5]  = 7'b0010010;
        segtab[6]  = 7'b0000010; segtab[7]  = 7'b1111000;
        segtab[8]  = 7'b0000000; segtab[9]  = 7'b0010000;
        segtab[10] = 7'b0001000; segtab[11] = 7'b0000011;
        segtab[12] = 7'b1000110; segtab[13] = 7'b0100001;
        segtab[14] = 7'b0000110; segtab[15] = 7'b0001110;

        rst_n = 1'b0;
        drive(8'hFF, 7'h7F);
        model_reset();
        tick(3);
        push_exp("reset");
        pop_check();
        chk("reset_frame", {31'h0, frame}, 32'h0);
        chk("reset_scan_err", {31'h0, scan_err}, 32'h0);
        rst_n = 1'b1;
        tick(3);
        frame_cnt = 0;
        err_cnt   = 0;

        // Full scan 0..7; first digit also checks the 2+STABLE_CYC+1 latency.
        for (int i = 0; i < 8; i++) begin
            drive(~(8'h01 << i), segtab[i]);
            if (i == 0) begin
                tick(6);
                chk("latency_pre_digits", digits, 32'h0);
                chk("latency_pre_blank", {24'h0, blank}, 32'hFF);
                tick(1);
                chk("latency_post_blank", {24'h0, blank}, 32'hFE);
                tick(3);
            end else begin
                tick(10);
            end
            model_cap(i, 4'(i), 1'b0, 1'b0);
            push_exp($sformatf("scan%0d", i));
            pop_check();
        end
        chk("scan_full_digits", digits, 32'h76543210);
        chk("scan_frame_count", frame_cnt, 1);
        chk("scan_err_none", err_cnt, 0);

        // Blank on position 3, then the letter A.
        drive(8'hF7, 7'b1111111);
        model_cap(3, 4'h0, 1'b1, 1'b0);
        push_exp("blank3");
        tick(10);
        pop_check();
        drive(8'hF7, 7'b0001000);
        model_cap(3, 4'hA, 1'b0, 1'b0);
        push_exp("digit3_A");
        tick(10);
        pop_check();

        // Two enables low: error pulse, no position updated.
        drive(8'hFC, segtab[1]);
        push_exp("two_low");
        tick(10);
        pop_check();
        chk("two_low_scan_err", err_cnt, 1);

        // Inputs never stable long enough: nothing captured.
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) drive(8'hFE, segtab[9]);
            else            drive(8'hFD, segtab[8]);
            tick(3);
        end
        push_exp("toggle");
        pop_check();
        chk("toggle_frame", frame_cnt, 1);
        chk("toggle_scan_err", err_cnt, 1);
        tick(10);
        model_cap(1, 4'h8, 1'b0, 1'b0);
        push_exp("toggle_settled");
        pop_check();

        // Illegal pattern on position 5.
        drive(8'hDF, 7'b1010101);
        model_cap(5, 4'h0, 1'b0, 1'b1);
        push_exp("bad5");
        tick(10);
        pop_check();
        chk("no_extra_frame", frame_cnt, 1);

        // Reset mid-settle abandons the dwell; a full window follows release.
        drive(8'hFB, segtab[5]);
        tick(4);
        rst_n = 1'b0;
        tick(2);
        model_reset();
        push_exp("reset_mid");
        pop_check();
        rst_n = 1'b1;
        tick(6);
        push_exp("post_reset_wait");
        pop_check();
        tick(1);
        model_cap(2, 4'h5, 1'b0, 1'b0);
        push_exp("post_reset_cap");
        pop_check();
        chk("final_scan_err", err_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sseg_capture.md
SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 Parameter NUM_DIGITS, default 8, SHALL be the number of scanned digit positions (1..8).
REQ-002 Parameter STABLE_CYC, default 4, SHALL be the cycles the scan inputs must hold unchanged before capture (1..255).
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 an_n  in  NUM_DIGITS  SHALL be the active-low digit enables of the scanned display.
REQ-006 seg_n  in  7  SHALL be the active-low segments {g,f,e,d,c,b,a} (bit 6 = g).
REQ-007 digits  out  4*NUM_DIGITS  SHALL hold the last decoded nibble per position; position i SHALL occupy bits [4i+3:4i].
REQ-008 blank  out  NUM_DIGITS  SHALL flag positions whose last capture was all segments off.
REQ-009 bad  out  NUM_DIGITS  SHALL flag positions whose last capture matched no legal pattern.
REQ-010 frame  out  1  SHALL pulse one cycle when every position has been captured since the previous pulse.
REQ-011 scan_err  out  1  SHALL pulse one cycle when an_n settles with zero or more than one bit low.

Function
REQ-012 Inputs SHALL pass through a two-flop synchronizer; all following rules apply to the synchronized values.
REQ-013 The FSM SHALL have states IDLE, SETTLE and HOLD.
REQ-014 IDLE: on any change of {an_n, seg_n}, go to SETTLE and load the stability counter with 1.
REQ-015 SETTLE: any input change SHALL reload the counter with 1; otherwise increment; on reaching STABLE_CYC, evaluate per REQ-016..018 and go to HOLD.
REQ-016 On evaluation with exactly one an_n bit low (index i): write digits[i], blank[i], bad[i] and set seen[i]; all other positions SHALL be unchanged.
REQ-017 Decode table (seg_n -> nibble): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
REQ-018 Pattern 1111111 SHALL set blank[i], clear bad[i] and write nibble 0; any other unlisted pattern SHALL set bad[i], clear blank[i] and write nibble 0.
REQ-019 On evaluation with zero or multiple an_n bits low: no position SHALL update; scan_err SHALL pulse the cycle after evaluation.
REQ-020 HOLD: exactly one capture per dwell; on any input change go to SETTLE with counter 1.
REQ-021 When seen becomes all ones, frame SHALL pulse the following cycle and seen SHALL clear in the same cycle; a capture coinciding with that clear SHALL set its seen bit afterwards.
REQ-022 Recapturing an already-seen position SHALL update its outputs but SHALL NOT pulse frame.
REQ-023 Total latency from a stable input change at the pins to updated outputs SHALL be 2 + STABLE_CYC + 1 cycles.

Reset
REQ-024 While rst_n is low: digits=0, blank=all ones, bad=0, seen=0, frame=0, scan_err=0, counter=0, state=IDLE, synchronizer flops=all ones.
REQ-025 Reset asserted mid-SETTLE or mid-HOLD SHALL abandon the dwell; after release the first capture SHALL require a full STABLE_CYC window.

Structure
REQ-026 The 16 segment codes, the blank code 7'b1111111 and the FSM state encoding SHALL live in shared package sseg_pkg.
REQ-027 The combinational pattern-to-nibble lookup SHALL be sub-module sseg_decode (outputs nibble, is_blank, is_bad); the rest SHALL stay in sseg_capture.

Verification
REQ-028 Scan 8 positions with values 0..7, each held 10 cycles -> digits=32'h76543210, blank=0, bad=0, one frame pulse.
REQ-029 Position 3 driven 1111111 -> blank[3]=1, digits[15:12]=0; later 0001000 -> blank[3]=0, digits[15:12]=A.
REQ-030 an_n=8'hFC (two digits low) held 10 cycles -> one scan_err pulse, no output change.
REQ-031 Inputs toggle every 3 cycles with STABLE_CYC=4 -> no capture, no frame, no scan_err.
REQ-032 Illegal pattern 1010101 on position 5 -> bad[5]=1, digits[23:20]=0.
REQ-033 rst_n low during SETTLE, released with inputs unchanged -> reset values hold; capture occurs only after a fresh stable window.
